program_loader: RTL

//   Writer side of the instruction-memory load port that I_FETCH reads through (i_loading/i_instruccion/i_address).

---
 rtl/program_loader_pkg.sv | 21 ++
 rtl/program_loader_byte_assembler.sv | 33 +++
 rtl/program_loader.sv | 126 ++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the instruction-memory program loader: FSM encoding,
// default end-of-program marker and the byte-address step between words.
package program_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RECV  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } loader_state_t;

   localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;
   localparam logic [31:0] ADDR_STEP         = 32'd4;
   localparam int          BYTES_PER_WORD    = 4;

   // A byte completes a word when the counter is about to wrap back to zero.
   function automatic logic is_last_byte(input logic [1:0] bcnt);
      return bcnt == 2'(BYTES_PER_WORD - 1);
   endfunction

endpackage

// File: rtl/program_loader_byte_assembler.sv
// Packs a byte stream into 32-bit words, MSB byte first. word_ready is high in
// the cycle the 4th byte is captured and word then holds the complete word.
module byte_assembler
   import program_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        capture,
   input  logic [7:0]  data,
   output logic [31:0] word,
   output logic        word_ready
);

   logic [31:0] shift;
   logic [1:0]  bcnt;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         shift <= '0;
         bcnt  <= '0;
      end else if (capture) begin
         shift <= {shift[23:0], data};
         bcnt  <= bcnt + 2'd1;
      end
   end

   // The completed word includes the byte arriving this cycle, so the writer
   // can latch it on the same edge that captures the last byte.
   assign word       = {shift[23:0], data};
   assign word_ready = capture && is_last_byte(bcnt);

endmodule

// File: rtl/program_loader.sv
// Loads a UART byte stream into instruction memory as 32-bit words at ascending
// byte addresses, holding the CPU in reset until HALT is written or memory fills.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    MEM_DEPTH  = 256,
   parameter logic [DATA_WIDTH-1:0] HALT_WORD  = DEFAULT_HALT_WORD
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic [7:0]            i_rx_data,
   input  logic                  i_rx_done,
   output logic                  o_loading,
   output logic [DATA_WIDTH-1:0] o_instruccion,
   output logic [DATA_WIDTH-1:0] o_address,
   output logic                  o_cpu_reset,
   output logic                  o_done,
   output logic                  o_overflow,
   output logic [DATA_WIDTH-1:0] o_word_count
);

   loader_state_t         state;
   loader_state_t         next_state;
   logic [DATA_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] word_count;
   logic [DATA_WIDTH-1:0] word_count_next;
   logic                  overflow;
   logic                  capture_en;
   logic                  start_load;
   logic                  halt_seen;
   logic                  mem_full;
   logic [31:0]           asm_word;
   logic                  word_ready;

   byte_assembler u_byte_assembler (
      .clk        (i_clock),
      .reset      (i_reset),
      .clear      (start_load),
      .capture    (capture_en),
      .data       (i_rx_data),
      .word       (asm_word),
      .word_ready (word_ready)
   );

   assign word_count_next = word_count + DATA_WIDTH'(1);
   assign halt_seen       = (o_instruccion == HALT_WORD);
   assign mem_full        = (word_count_next == DATA_WIDTH'(MEM_DEPTH));

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Bytes are accepted in WRITE as well as RECV so a byte landing in the
   // write cycle becomes byte 0 of the following word.
   always_comb begin
      next_state = state;
      capture_en = 1'b0;
      start_load = 1'b0;
      unique case (state)
         ST_IDLE, ST_DONE: begin
            if (i_start) begin
               next_state = ST_RECV;
               start_load = 1'b1;
            end
         end
         ST_RECV: begin
            capture_en = i_rx_done;
            if (word_ready) begin
               next_state = ST_WRITE;
            end
         end
         ST_WRITE: begin
            capture_en = i_rx_done;
            if (halt_seen || mem_full) begin
               next_state = ST_DONE;
            end else begin
               next_state = ST_RECV;
            end
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // The write registers are loaded on the edge that captures the 4th byte,
   // so they are stable for the whole WRITE cycle and hold afterwards.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         addr          <= '0;
         word_count    <= '0;
         overflow      <= 1'b0;
         o_instruccion <= '0;
         o_address     <= '0;
      end else begin
         if (start_load) begin
            addr       <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
         end else if (state == ST_WRITE) begin
            addr       <= addr + DATA_WIDTH'(ADDR_STEP);
            word_count <= word_count_next;
            if (!halt_seen && mem_full) begin
               overflow <= 1'b1;
            end
         end
         if (word_ready) begin
            o_instruccion <= DATA_WIDTH'(asm_word);
            o_address     <= addr;
         end
      end
   end

   assign o_loading    = (state == ST_WRITE);
   assign o_cpu_reset  = (state == ST_RECV) || (state == ST_WRITE);
   assign o_done       = (state == ST_DONE);
   assign o_overflow   = overflow;
   assign o_word_count = word_count;

endmodule
